// File: rtl/bp_fe_queue_rolly_ctrl.sv
// Sequencer for the rollback-capable FE->BE queue: turns issue/commit/replay/flush events into
// yumi/deq/roll/clr strobes. Optional perf counters are built when BP_ROLLY_CTRL_PERF_EN is defined.
module bp_fe_queue_rolly_ctrl #(
  parameter int fifo_els_p   = 8,
  parameter int perf_width_p = 16,
  localparam int cnt_width_lp = $clog2(fifo_els_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      fifo_v_i,
  input  logic                      issue_ready_i,
  input  logic                      commit_v_i,
  input  logic                      replay_v_i,
  input  logic                      redirect_v_i,
  input  logic                      flush_v_i,
  output logic                      fifo_yumi_o,
  output logic                      fifo_deq_o,
  output logic                      fifo_roll_o,
  output logic                      fifo_clr_o,
  output logic                      issue_v_o,
  output logic                      busy_o,
  output logic [cnt_width_lp-1:0]   inflight_o,
  output logic                      err_o,
  output logic [3*perf_width_p-1:0] perf_o,
  output logic [1:0]                state_o
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_FLUSH_ROLL = 2'd1,
    S_FLUSH_CLR  = 2'd2
  } state_e;

  localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(fifo_els_p);

  // Handshake: every strobe is a single-cycle pulse computed combinationally from the registered
  // state and this cycle's inputs; the queue acts on it at the next clock edge, no back-pressure.

  state_e                  state_r, state_n;
  logic                    armed_r;
  logic [cnt_width_lp-1:0] inflight_r, inflight_n;
  logic                    err_r;
  logic                    yumi, deq, roll, clr, err_set;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= S_RUN;
      armed_r    <= 1'b0;
      inflight_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      armed_r    <= 1'b1;
      inflight_r <= inflight_n;
      err_r      <= err_r | err_set;
    end
  end

  // armed_r holds every strobe low for the first cycle after reset release.
  always_comb begin
    state_n    = state_r;
    inflight_n = inflight_r;
    yumi       = 1'b0;
    deq        = 1'b0;
    roll       = 1'b0;
    clr        = 1'b0;
    err_set    = 1'b0;
    if (armed_r) begin
      deq     = commit_v_i & (inflight_r != '0);
      err_set = commit_v_i & (inflight_r == '0);
      case (state_r)
        S_RUN: begin
          if (flush_v_i) begin
            roll    = 1'b1;
            state_n = S_FLUSH_ROLL;
          end else if (replay_v_i) begin
            roll = 1'b1;
          end else if (redirect_v_i) begin
            clr = 1'b1;
          end
          yumi = fifo_v_i & issue_ready_i & (inflight_r != full_lp) & ~roll;
        end
        S_FLUSH_ROLL: begin
          clr     = 1'b1;
          state_n = S_FLUSH_CLR;
        end
        S_FLUSH_CLR: state_n = S_RUN;
        default:     state_n = S_RUN;
      endcase
      // A roll moves the checkpoint too, so any same-cycle deq is absorbed by the reset to zero.
      if (roll || (state_r == S_FLUSH_ROLL)) begin
        inflight_n = '0;
      end else if (yumi && !deq) begin
        inflight_n = inflight_r + cnt_width_lp'(1);
      end else if (deq && !yumi) begin
        inflight_n = inflight_r - cnt_width_lp'(1);
      end
    end
  end

  assign fifo_yumi_o = yumi;
  assign issue_v_o   = yumi;
  assign fifo_deq_o  = deq;
  assign fifo_roll_o = roll;
  assign fifo_clr_o  = clr;
  assign busy_o      = (state_r != S_RUN);
  assign inflight_o  = inflight_r;
  assign err_o       = err_r;
  assign state_o     = state_r;

`ifdef BP_ROLLY_CTRL_PERF_EN
  logic [perf_width_p-1:0] stall_cnt_r, flush_cnt_r, roll_cnt_r;
  logic                    flush_enter, stall;

  assign flush_enter = (state_r == S_RUN) && (state_n == S_FLUSH_ROLL);
  assign stall       = armed_r & fifo_v_i & issue_ready_i & ~yumi;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
      roll_cnt_r  <= '0;
    end else begin
      if (stall && (stall_cnt_r != '1))       stall_cnt_r <= stall_cnt_r + perf_width_p'(1);
      if (flush_enter && (flush_cnt_r != '1)) flush_cnt_r <= flush_cnt_r + perf_width_p'(1);
      if (roll && (roll_cnt_r != '1))         roll_cnt_r  <= roll_cnt_r + perf_width_p'(1);
    end
  end

  assign perf_o = {stall_cnt_r, flush_cnt_r, roll_cnt_r};
`else
  assign perf_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_queue_rolly_ctrl.sv
// Self-checking bench for bp_fe_queue_rolly_ctrl: a cycle model pushes expected outputs to a queue
// as stimulus is driven; each scenario task pops and compares them, plus fixed scenario expectations.
module tb_bp_fe_queue_rolly_ctrl;
  localparam int ELS = 8;
  localparam int PW  = 16;
  localparam int CW  = 4;
  localparam int W   = 11;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic fifo_v = 0, issue_ready = 0, commit_v = 0, replay_v = 0, redirect_v = 0, flush_v = 0;
  logic yumi, deq, roll, clr, issue_v, busy, err;
  logic [CW-1:0]   inflight;
  logic [3*PW-1:0] perf;
  logic [1:0]      state_dbg;

  bp_fe_queue_rolly_ctrl #(.fifo_els_p(ELS), .perf_width_p(PW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fifo_v_i(fifo_v), .issue_ready_i(issue_ready), .commit_v_i(commit_v),
    .replay_v_i(replay_v), .redirect_v_i(redirect_v), .flush_v_i(flush_v),
    .fifo_yumi_o(yumi), .fifo_deq_o(deq), .fifo_roll_o(roll), .fifo_clr_o(clr),
    .issue_v_o(issue_v), .busy_o(busy), .inflight_o(inflight), .err_o(err),
    .perf_o(perf), .state_o(state_dbg)
  );

  wire [W-1:0] obs = {yumi, issue_v, deq, roll, clr, busy, err, inflight};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  int m_state, m_inflight, m_stall, m_flush, m_roll;
  bit m_err, m_armed;

  task automatic model_reset();
    m_state = 0; m_inflight = 0; m_err = 0; m_armed = 0;
    m_stall = 0; m_flush = 0; m_roll = 0;
  endtask

  function automatic logic [3*PW-1:0] exp_perf();
`ifdef BP_ROLLY_CTRL_PERF_EN
    return {PW'(m_stall), PW'(m_flush), PW'(m_roll)};
`else
    return '0;
`endif
  endfunction

  task automatic model_step();
    logic y, d, r, c, b;
    int ns, ni;
    y = 0; d = 0; r = 0; c = 0;
    b = (m_state != 0);
    ns = m_state; ni = m_inflight;
    if (m_armed) begin
      d = commit_v && (m_inflight != 0);
      case (m_state)
        0: begin
          if (flush_v) begin r = 1; ns = 1; m_flush++; end
          else if (replay_v) r = 1;
          else if (redirect_v) c = 1;
          y = fifo_v && issue_ready && (m_inflight != ELS) && !r;
        end
        1: begin c = 1; ns = 2; end
        default: ns = 0;
      endcase
      if (r) m_roll++;
      if (fifo_v && issue_ready && !y) m_stall++;
      if (r || m_state == 1) ni = 0;
      else ni = m_inflight + int'(y) - int'(d);
    end
    exp_q.push_back({y, y, d, r, c, b, m_err, CW'(m_inflight)});
    if (m_armed && commit_v && m_inflight == 0) m_err = 1;
    m_state = ns; m_inflight = ni; m_armed = 1;
  endtask

  // driver
  task automatic drive(input logic fv, ir, cv, rv, rdv, fl);
    @(negedge clk);
    fifo_v = fv; issue_ready = ir; commit_v = cv;
    replay_v = rv; redirect_v = rdv; flush_v = fl;
    model_step();
  endtask

  task automatic test_reset();
    reset_n = 0;
    fifo_v = 1; issue_ready = 1; commit_v = 1; replay_v = 0; redirect_v = 1; flush_v = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== '0 || perf !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state obs=%b perf=%h state=%0d required all zero", obs, perf, state_dbg);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1;
    model_step();
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_first_cycle obs=%b required %b", obs, exp_v);
    end
    checks++;
    if (yumi !== 1'b0 || clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_strobes yumi=%b clr=%b required 0 0", yumi, clr);
    end
  endtask

  task automatic test_reads();
    int ny;
    ny = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      #1;
      if (yumi === 1'b1) ny++;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reads_cyc%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (ny != 8 || inflight !== 4'd8 || obs !== exp_v) begin
      errors++;
      $display("FAIL reads_total yumis=%0d inflight=%0d required 8 8", ny, inflight);
    end
    checks++;
`ifdef BP_ROLLY_CTRL_PERF_EN
    if (perf[3*PW-1:2*PW] !== PW'(2) || perf !== exp_perf()) begin
`else
    if (perf !== '0) begin
`endif
      errors++;
      $display("FAIL reads_perf perf=%h required %h", perf, exp_perf());
    end
  endtask

  task automatic test_commit();
    int nd;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL commit_drain%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      #1;
      if (deq === 1'b1) nd++;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL commit_cyc%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    drive(0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (nd != 3 || inflight !== 4'd0 || err !== 1'b0 || deq !== 1'b0) begin
      errors++;
      $display("FAIL commit_underflow deqs=%0d inflight=%0d err=%b deq=%b required 3 0 0 0",
               nd, inflight, err, deq);
    end
    exp_v = exp_q.pop_front();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL commit_err err=%b required 1", err);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL commit_idle obs=%b required %b", obs, exp_v);
    end
  endtask

  task automatic test_replay();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL replay_fill%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    drive(1, 1, 1, 1, 0, 0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (roll !== 1'b1 || deq !== 1'b1 || yumi !== 1'b0 || inflight !== 4'd5 || obs !== exp_v) begin
      errors++;
      $display("FAIL replay_cycle roll=%b deq=%b yumi=%b inflight=%0d required 1 1 0 5",
               roll, deq, yumi, inflight);
    end
    drive(1, 1, 0, 0, 0, 0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (inflight !== 4'd0 || yumi !== 1'b1 || obs !== exp_v) begin
      errors++;
      $display("FAIL replay_resume inflight=%0d yumi=%b required 0 1", inflight, yumi);
    end
  endtask

  task automatic test_flush();
    logic [4:0] want [4];
    int f0;
    // {roll, clr, busy, yumi, inflight_is_zero}
    want[0] = 5'b10000; want[1] = 5'b01101; want[2] = 5'b00101; want[3] = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL flush_fill%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    f0 = m_flush;
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive(1, 1, 0, 0, 0, 1);
      else if (c < 3)  drive(1, 1, 0, 1, 1, 1);
      else             drive(0, 0, 0, 0, 0, 0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({roll, clr, busy, yumi, inflight == 4'd0} !== want[c] || obs !== exp_v) begin
        errors++;
        $display("FAIL flush_cyc%0d roll/clr/busy/yumi/zero=%b required %b inflight=%0d",
                 c, {roll, clr, busy, yumi, inflight == 4'd0}, want[c], inflight);
      end
    end
    checks++;
`ifdef BP_ROLLY_CTRL_PERF_EN
    if (perf[2*PW-1:PW] !== PW'(f0 + 1) || perf !== exp_perf()) begin
`else
    if (perf !== '0 || m_flush != f0 + 1) begin
`endif
      errors++;
      $display("FAIL flush_perf perf=%h required %h", perf, exp_perf());
    end
  endtask

  task automatic test_redirect();
    drive(1, 1, 0, 0, 1, 0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (clr !== 1'b1 || yumi !== 1'b1 || obs !== exp_v) begin
      errors++;
      $display("FAIL redirect_read clr=%b yumi=%b required 1 1", clr, yumi);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 15) == 0));
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_cyc%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    checks++;
    if (perf !== exp_perf()) begin
      errors++;
      $display("FAIL random_perf perf=%h required %h", perf, exp_perf());
    end
  endtask

  task automatic test_reset_mid_flush();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rmf_idle%0d obs=%b required %b", i, obs, exp_v);
      end
    end
    drive(1, 1, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 1, 0);
    #1;
    exp_v = exp_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL rmf_in_roll obs=%b state=%0d required %b 1", obs, state_dbg, exp_v);
    end
    #1;
    reset_n = 0;
    #1;
    checks++;
    if (obs !== '0 || perf !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rmf_async obs=%b perf=%h state=%0d required all zero", obs, perf, state_dbg);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1;
    fifo_v = 0; issue_ready = 0; commit_v = 0; replay_v = 0; redirect_v = 0; flush_v = 0;
    model_step();
    drive(1, 1, 0, 0, 0, 0);
    #1;
    exp_v = exp_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || state_dbg !== 2'd0 || perf !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmf_release obs=%b state=%0d perf=%h required %b 0 0", obs, state_dbg, perf, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_reads();
    test_commit();
    test_replay();
    test_flush();
    test_redirect();
    test_back_to_back();
    test_reset_mid_flush();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
